// File: rtl/arb_prio_seq.sv
// Purpose: registered N-channel request/grant arbiter; holds one grant until release, then re-arbitrates.
// Latency: 1 cycle req->gnt, 1 cycle release->clear, mandatory idle cycle between grants.
// Backpressure: none; requesters must hold req until granted. ARB_PRIO_SEQ_ROUND_ROBIN_EN selects round-robin.
module arb_prio_seq #(
    parameter int N    = 8,
    parameter int IDXW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_vld
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] win_idx;

`ifdef ARB_PRIO_SEQ_ROUND_ROBIN_EN
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] lo_idx;
    logic            lo_any;
`endif

    // Winner: highest set index; in round-robin mode, prefer the highest set index below ptr.
    always_comb begin
        win_idx = '0;
`ifdef ARB_PRIO_SEQ_ROUND_ROBIN_EN
        lo_idx  = '0;
        lo_any  = 1'b0;
`endif
        for (int k = 0; k < N; k++) begin
            if (req[k]) begin
                win_idx = IDXW'(k);
`ifdef ARB_PRIO_SEQ_ROUND_ROBIN_EN
                if (k < int'(ptr_q)) begin
                    lo_idx = IDXW'(k);
                    lo_any = 1'b1;
                end
`endif
            end
        end
`ifdef ARB_PRIO_SEQ_ROUND_ROBIN_EN
        if (lo_any) begin
            win_idx = lo_idx;
        end
`endif
    end

    // Next-state: grant from IDLE on any request, release from GRANT on done or dropped request.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
`ifdef ARB_PRIO_SEQ_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_GRANT;
                    gnt_d   = N'(1) << win_idx;
                    idx_d   = win_idx;
`ifdef ARB_PRIO_SEQ_ROUND_ROBIN_EN
                    ptr_d   = win_idx;
`endif
                end
            end
            S_GRANT: begin
                // gnt_q is one-hot, so masking req with it tests the granted channel's request.
                if (done || ((req & gnt_q) == '0)) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                end
            end
        endcase
    end

    // State and grant registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
`ifdef ARB_PRIO_SEQ_ROUND_ROBIN_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
`ifdef ARB_PRIO_SEQ_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = |gnt_q;

endmodule

// File: tb/tb_arb_prio_seq.sv
// Testbench for arb_prio_seq (N=8): directed scenarios plus random traffic against a reference model.
// Inputs are driven 1 time unit after a rising edge, outputs sampled 1 time unit after the next one.
// Works for both builds; ARB_PRIO_SEQ_ROUND_ROBIN_EN switches the expected winners.
module tb_arb_prio_seq;

    localparam int N    = 8;
    localparam int IDXW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic            done;
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_vld;

    int total = 0;
    int bad   = 0;

    // Reference model state: whether a grant is held and on which channel.
    bit m_vld = 1'b0;
    int m_idx = 0;
`ifdef ARB_PRIO_SEQ_ROUND_ROBIN_EN
    int m_ptr = 0;
`endif

    arb_prio_seq #(.N(N), .IDXW(IDXW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always #5 clk = ~clk;

    // Walk the priority order literally and return the first requesting channel.
    function automatic int pick(input logic [N-1:0] r);
`ifdef ARB_PRIO_SEQ_ROUND_ROBIN_EN
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (((m_ptr - i) % N) + N) % N;
            if (r[c]) return c;
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (r[i]) return i;
        end
`endif
        return 0;
    endfunction

    function automatic logic [N-1:0] m_gnt();
        logic [N-1:0] one;
        one = 1;
        return m_vld ? (one << m_idx) : '0;
    endfunction

    // Apply one cycle of inputs, advance the model at the edge, then settle past it.
    task automatic step(input logic [N-1:0] r, input logic d, input logic rs);
        req  = r;
        done = d;
        rst  = rs;
        @(posedge clk);
        if (rs) begin
            m_vld = 1'b0;
            m_idx = 0;
`ifdef ARB_PRIO_SEQ_ROUND_ROBIN_EN
            m_ptr = 0;
`endif
        end else if (!m_vld) begin
            if (r != '0) begin
                m_idx = pick(r);
                m_vld = 1'b1;
`ifdef ARB_PRIO_SEQ_ROUND_ROBIN_EN
                m_ptr = m_idx;
`endif
            end
        end else if (d || !r[m_idx]) begin
            m_vld = 1'b0;
            m_idx = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(8'hFF, 1'b0, 1'b1);
            total++;
            if ({gnt, gnt_idx, gnt_vld} !== {8'h00, 3'd0, 1'b0}) begin
                bad++;
                $display("FAIL reset[%0d]: got gnt=%h idx=%0d vld=%b want gnt=00 idx=0 vld=0", i, gnt, gnt_idx, gnt_vld);
            end
        end
        step(8'hFF, 1'b0, 1'b0);
        total++;
        if ({gnt, gnt_idx, gnt_vld} !== {8'h80, 3'd7, 1'b1}) begin
            bad++;
            $display("FAIL reset_first_grant: got gnt=%h idx=%0d vld=%b want gnt=80 idx=7 vld=1", gnt, gnt_idx, gnt_vld);
        end
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        total++;
        if ({gnt, gnt_idx, gnt_vld} !== {8'h00, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL idle_after_drop: got gnt=%h idx=%0d vld=%b want gnt=00 idx=0 vld=0", gnt, gnt_idx, gnt_vld);
        end
    endtask

    task automatic test_hold();
        step(8'b0010_0100, 1'b0, 1'b0);
        total++;
        if ({gnt, gnt_idx, gnt_vld} !== {8'b0010_0000, 3'd5, 1'b1}) begin
            bad++;
            $display("FAIL hold_grant: got gnt=%h idx=%0d vld=%b want gnt=20 idx=5 vld=1", gnt, gnt_idx, gnt_vld);
        end
        for (int i = 0; i < 5; i++) begin
            step(8'b1010_0100, 1'b0, 1'b0);
            total++;
            if ({gnt, gnt_idx, gnt_vld} !== {8'b0010_0000, 3'd5, 1'b1}) begin
                bad++;
                $display("FAIL hold_cycle[%0d]: got gnt=%h idx=%0d vld=%b want gnt=20 idx=5 vld=1", i, gnt, gnt_idx, gnt_vld);
            end
        end
    endtask

    task automatic test_done_pulse();
        logic [N-1:0]    e_gnt;
        logic [IDXW-1:0] e_idx;
`ifdef ARB_PRIO_SEQ_ROUND_ROBIN_EN
        e_gnt = 8'h04;
        e_idx = 3'd2;
`else
        e_gnt = 8'h20;
        e_idx = 3'd5;
`endif
        step(8'b0010_0100, 1'b1, 1'b0);
        total++;
        if ({gnt, gnt_idx, gnt_vld} !== {8'h00, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL done_clear: got gnt=%h idx=%0d vld=%b want gnt=00 idx=0 vld=0", gnt, gnt_idx, gnt_vld);
        end
        step(8'b0010_0100, 1'b0, 1'b0);
        total++;
        if ({gnt, gnt_idx, gnt_vld} !== {e_gnt, e_idx, 1'b1}) begin
            bad++;
            $display("FAIL done_regrant: got gnt=%h idx=%0d vld=%b want gnt=%h idx=%0d vld=1", gnt, gnt_idx, gnt_vld, e_gnt, e_idx);
        end
        step(8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int seq [9];
`ifdef ARB_PRIO_SEQ_ROUND_ROBIN_EN
        seq = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
`else
        seq = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
`endif
        step(8'hFF, 1'b0, 1'b1);
        // done is held high throughout: it is ignored while idle and releases each grant after one cycle.
        for (int k = 0; k < 18; k++) begin
            step(8'hFF, 1'b1, 1'b0);
            total++;
            if (k % 2 == 0) begin
                if ({gnt, gnt_idx, gnt_vld} !== {8'h01 << seq[k/2], 3'(seq[k/2]), 1'b1}) begin
                    bad++;
                    $display("FAIL b2b_grant[%0d]: got gnt=%h idx=%0d vld=%b want idx=%0d vld=1", k/2, gnt, gnt_idx, gnt_vld, seq[k/2]);
                end
            end else begin
                if ({gnt, gnt_idx, gnt_vld} !== {8'h00, 3'd0, 1'b0}) begin
                    bad++;
                    $display("FAIL b2b_idle[%0d]: got gnt=%h idx=%0d vld=%b want gnt=00 idx=0 vld=0", k/2, gnt, gnt_idx, gnt_vld);
                end
            end
        end
    endtask

    task automatic test_req_drop();
        step(8'h08, 1'b0, 1'b0);
        total++;
        if ({gnt, gnt_idx, gnt_vld} !== {8'h08, 3'd3, 1'b1}) begin
            bad++;
            $display("FAIL drop_grant3: got gnt=%h idx=%0d vld=%b want gnt=08 idx=3 vld=1", gnt, gnt_idx, gnt_vld);
        end
        step(8'h01, 1'b0, 1'b0);
        total++;
        if ({gnt, gnt_idx, gnt_vld} !== {8'h00, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL drop_clear: got gnt=%h idx=%0d vld=%b want gnt=00 idx=0 vld=0", gnt, gnt_idx, gnt_vld);
        end
        step(8'h01, 1'b0, 1'b0);
        total++;
        if ({gnt, gnt_idx, gnt_vld} !== {8'h01, 3'd0, 1'b1}) begin
            bad++;
            $display("FAIL drop_regrant: got gnt=%h idx=%0d vld=%b want gnt=01 idx=0 vld=1", gnt, gnt_idx, gnt_vld);
        end
        step(8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_rst_mid_grant();
        step(8'h04, 1'b0, 1'b0);
        total++;
        if ({gnt, gnt_idx, gnt_vld} !== {8'h04, 3'd2, 1'b1}) begin
            bad++;
            $display("FAIL rstmid_grant2: got gnt=%h idx=%0d vld=%b want gnt=04 idx=2 vld=1", gnt, gnt_idx, gnt_vld);
        end
        step(8'h04, 1'b0, 1'b1);
        total++;
        if ({gnt, gnt_idx, gnt_vld} !== {8'h00, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL rstmid_clear: got gnt=%h idx=%0d vld=%b want gnt=00 idx=0 vld=0", gnt, gnt_idx, gnt_vld);
        end
        step(8'h81, 1'b0, 1'b0);
        total++;
        if ({gnt, gnt_idx, gnt_vld} !== {8'h80, 3'd7, 1'b1}) begin
            bad++;
            $display("FAIL rstmid_ptr: got gnt=%h idx=%0d vld=%b want gnt=80 idx=7 vld=1", gnt, gnt_idx, gnt_vld);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic         d;
        logic         rs;
        step(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            r = N'($urandom);
            if ($urandom_range(0, 2) == 0) r = r & N'($urandom);
            if ($urandom_range(0, 5) == 0) r = '0;
            if (m_vld && $urandom_range(0, 3) != 0) r[m_idx] = 1'b1;
            d  = ($urandom_range(0, 4) == 0);
            rs = ($urandom_range(0, 59) == 0);
            step(r, d, rs);
            total++;
            if (gnt !== m_gnt() || gnt_idx !== IDXW'(m_idx) || gnt_vld !== m_vld) begin
                bad++;
                $display("FAIL random[%0d]: req=%h done=%b rst=%b got gnt=%h idx=%0d vld=%b want gnt=%h idx=%0d vld=%b",
                         i, r, d, rs, gnt, gnt_idx, gnt_vld, m_gnt(), m_idx, m_vld);
            end
            total++;
            if (!$onehot0(gnt)) begin
                bad++;
                $display("FAIL random_onehot[%0d]: got gnt=%h want zero or one-hot", i, gnt);
            end
        end
    endtask

    initial begin
        req  = '0;
        done = 1'b0;
        rst  = 1'b1;
        test_reset();
        test_hold();
        test_done_pulse();
        test_back_to_back();
        step(8'h00, 1'b0, 1'b0);
        test_req_drop();
        test_rst_mid_grant();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
